scratchpad_ctrl: RTL and testbench
==================================

# scratchpad_ctrl

Request controller that sits directly upstream of the byte-addressed 64-bit scratchpad RAM. It accepts one load/store request at a time over a valid/ready handshake, drives the RAM's en/wr/len/addr/wdata port, and returns a response over a second valid/ready handshake. Sub-word stores use read-modify-write so that neighbouring bytes are preserved, because the RAM zero-fills unused bytes. It also bounds-checks every access, and masks load data to the requested size.

## Interface
- ADDR_WIDTH, 10, byte-address width; RAM depth is 2**ADDR_WIDTH bytes (minimum 4)
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE and not in reset
- req_wr  in  1  1=store, 0=load
- req_len  in  2  size code: 0=1B, 1=2B, 2=4B, 3=8B (N = 1<<req_len)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  64  store data; bytes 0..N-1 significant
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed
- resp_rdata  out  64  load data, bytes >= N zeroed; 0 for stores and errors
- resp_err  out  1  out-of-bounds request; no RAM access made
- ram_en, ram_wr  out  1 each  RAM enable / write
- ram_len  out  2  RAM size code
- ram_addr  out  ADDR_WIDTH  RAM byte address
- ram_wdata  out  64  RAM write data
- ram_rdata  in  64  RAM read data; registered in the RAM on the edge where ram_en & ~ram_wr

## Operation
- States: IDLE, RD, CAP, WR, RESP. One request outstanding at most.
- IDLE: req_ready=1. On req_valid & req_ready, latch wr/len/addr/wdata.
  - If req_addr > 2**ADDR_WIDTH-8, go to RESP with err=1 and rdata=0. All accesses physically touch 8 bytes.
  - Else if load, go to RD.
  - Else if store with len=3, go to WR.
  - Else (sub-word store), go to RD.
- RD: ram_en=1, ram_wr=0, ram_len=3, ram_addr=latched addr. Go to CAP.
- CAP: ram_rdata is valid.
  - Load: resp_rdata <= ram_rdata with bytes >= N zeroed; go to RESP.
  - Store: merge register <= bytes 0..N-1 from latched wdata, rest from ram_rdata; go to WR.
- WR: ram_en=1, ram_wr=1, ram_len=3, ram_wdata = merge register (or latched wdata when len=3). Go to RESP with rdata=0.
- RESP: resp_valid=1, with rdata/err held stable. On resp_ready, go to IDLE.
- Outside RD and WR, ram_en=0. ram_addr, ram_wdata and ram_len are don't-care when ram_en=0.
- resp_valid and req_ready are never high in the same cycle.

## Timing
- Reset values: state IDLE; resp_valid=0, resp_err=0, resp_rdata=0, ram_en=0, ram_wr=0, merge register=0. req_ready=0 while reset is high, and 1 in the first cycle after.
- Let cycle 0 be the accept edge. Response first valid in:
  - load: cycle 3
  - full store: cycle 2
  - sub-word store: cycle 4
  - error: cycle 1
- Back-to-back: with resp_ready held high, the next accept happens in the cycle after the response cycle. Minimum issue interval = latency+1.
- resp_valid stalls indefinitely if resp_ready stays low. No RAM activity occurs while stalled.
- Reset mid-operation: return to IDLE at the next edge with no further RAM cycles. A RAM write already issued on that edge completes. A pending response is dropped.
- Boundary: addr = 2**ADDR_WIDTH-8 is legal. 2**ADDR_WIDTH-7 and above error for every len.

## Configuration
- SCRATCHPAD_CTRL_RMW_EN defined: sub-word stores use RD→CAP→WR as above.
- Not defined: every store goes IDLE→WR→RESP.
  - ram_len = req_len and ram_wdata = req_wdata.
  - The RAM zero-fills bytes N..7 at addr.
  - Latency is 2 for all stores, and the CAP merge path is absent.

## Test plan
- Store 8B 0x1122334455667788 at 0x10, then load 8B at 0x10 → rdata 0x1122334455667788, err=0, load resp in cycle 3.
- With RMW enabled: preload 0x1122334455667788 at 0x10, store 1B 0xAB at 0x12, load 8B at 0x10 → 0x11223344 55AB7788 (byte 2 replaced, others kept); store resp in cycle 4.
- Load 2B at 0x10 after the preload → rdata 0x0000000000007788.
- Load at 2**ADDR_WIDTH-7 → resp_err=1, rdata=0, ram_en never asserted. At 2**ADDR_WIDTH-8 → err=0.
- Hold resp_ready low for 5 cycles → resp_valid and data stable, req_ready=0, ram_en=0. Then pulse resp_ready → back-to-back next request accepted the following cycle.
- Assert reset in CAP of a sub-word store → no write cycle, resp_valid=0, memory at addr unchanged.

Source files
------------

// File: rtl/scratchpad_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : scratchpad_ctrl_if
//  Description : Request/response handshake bundle between a client and the
//                scratchpad request controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface scratchpad_ctrl_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [1:0]            req_len;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [63:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [63:0]           resp_rdata;
    logic                  resp_err;

    // Client side: issues requests, consumes responses.
    modport master (
        output req_valid, req_wr, req_len, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Controller side.
    modport slave (
        input  req_valid, req_wr, req_len, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/scratchpad_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scratchpad_ctrl
//  Description : Single-outstanding load/store controller in front of a
//                byte-addressed 64-bit scratchpad RAM. Bounds-checks every
//                access, masks load data to the requested size and, when
//                SCRATCHPAD_CTRL_RMW_EN is defined, performs read-modify-write
//                for sub-word stores so neighbouring bytes survive the RAM's
//                zero-fill. Without the macro every store is a direct sized
//                write.
//  Revision    : 1.0  initial release
// ============================================================================
module scratchpad_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    scratchpad_ctrl_if.slave           bus,
    output logic                       ram_en,
    output logic                       ram_wr,
    output logic [1:0]                 ram_len,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    output logic [63:0]                ram_wdata,
    input  wire logic [63:0]           ram_rdata
);

    // Highest legal start address: every access physically spans 8 bytes.
    localparam logic [ADDR_WIDTH-1:0] c_MAX_ADDR = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(7);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_wr;
    logic [1:0]            r_len;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [63:0]           r_wdata;
    logic [63:0]           r_resp_rdata;
    logic                  r_resp_err;
`ifdef SCRATCHPAD_CTRL_RMW_EN
    logic [63:0]           r_merge;
`endif

    logic                  w_accept;
    logic                  w_oob;
    logic [63:0]           w_mask;

    // Byte-lane mask covering bytes 0..N-1 of the requested size.
    function automatic logic [63:0] byte_mask(input logic [1:0] len);
        case (len)
            2'd0:    byte_mask = 64'h0000_0000_0000_00FF;
            2'd1:    byte_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    byte_mask = 64'h0000_0000_FFFF_FFFF;
            default: byte_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    assign bus.req_ready  = (r_state == S_IDLE) && !reset;
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

    assign w_accept = bus.req_valid && bus.req_ready;
    assign w_oob    = (bus.req_addr > c_MAX_ADDR);
    assign w_mask   = byte_mask(r_len);
    assign ram_addr = r_addr;

`ifdef SCRATCHPAD_CTRL_RMW_EN
    assign ram_wdata = (r_len == 2'd3) ? r_wdata : r_merge;
`else
    assign ram_wdata = r_wdata;
`endif

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and RAM port strobes.
    always_comb begin
        w_next  = r_state;
        ram_en  = 1'b0;
        ram_wr  = 1'b0;
        ram_len = 2'd3;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_oob) begin
                        w_next = S_RESP;
                    end else if (!bus.req_wr) begin
                        w_next = S_RD;
                    end else begin
`ifdef SCRATCHPAD_CTRL_RMW_EN
                        w_next = (bus.req_len == 2'd3) ? S_WR : S_RD;
`else
                        w_next = S_WR;
`endif
                    end
                end
            end
            S_RD: begin
                ram_en = 1'b1;
                w_next = S_CAP;
            end
            S_CAP: begin
                w_next = r_wr ? S_WR : S_RESP;
            end
            S_WR: begin
                ram_en = 1'b1;
                ram_wr = 1'b1;
`ifndef SCRATCHPAD_CTRL_RMW_EN
                ram_len = r_len;
`endif
                w_next = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch, load-data capture and store-merge datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr         <= 1'b0;
            r_len        <= 2'd0;
            r_addr       <= '0;
            r_wdata      <= 64'd0;
            r_resp_rdata <= 64'd0;
            r_resp_err   <= 1'b0;
`ifdef SCRATCHPAD_CTRL_RMW_EN
            r_merge      <= 64'd0;
`endif
        end else begin
            if (w_accept) begin
                r_wr         <= bus.req_wr;
                r_len        <= bus.req_len;
                r_addr       <= bus.req_addr;
                r_wdata      <= bus.req_wdata;
                r_resp_rdata <= 64'd0;
                r_resp_err   <= w_oob;
            end
            if (r_state == S_CAP) begin
                if (!r_wr) begin
                    r_resp_rdata <= ram_rdata & w_mask;
                end
`ifdef SCRATCHPAD_CTRL_RMW_EN
                else begin
                    r_merge <= (r_wdata & w_mask) | (ram_rdata & ~w_mask);
                end
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scratchpad_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scratchpad_ctrl
//  Description : Self-checking bench for scratchpad_ctrl with a byte-array
//                RAM model and a byte-array reference memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scratchpad_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          ram_en;
    logic          ram_wr;
    logic [1:0]    ram_len;
    logic [AW-1:0] ram_addr;
    logic [63:0]   ram_wdata;
    logic [63:0]   ram_rdata;
    logic          ram_clear;

    int total = 0;
    int bad   = 0;

    int ram_en_cnt = 0;
    int ram_wr_cnt = 0;

    logic [7:0] ram_mem [DEPTH];
    logic [7:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    scratchpad_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    scratchpad_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_wr    (ram_wr),
        .ram_len   (ram_len),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Scratchpad RAM: registered read, sized write with zero-fill of bytes N..7.
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 8'h00;
            ram_rdata <= 64'd0;
        end else if (ram_en) begin
            ram_en_cnt <= ram_en_cnt + 1;
            if (ram_wr) begin
                ram_wr_cnt <= ram_wr_cnt + 1;
                for (int i = 0; i < 8; i++)
                    if (int'(ram_addr) + i < DEPTH)
                        ram_mem[int'(ram_addr) + i] <= (i < (1 << ram_len)) ? ram_wdata[i*8 +: 8] : 8'h00;
            end else begin
                for (int i = 0; i < 8; i++)
                    ram_rdata[i*8 +: 8] <= (int'(ram_addr) + i < DEPTH) ? ram_mem[int'(ram_addr) + i] : 8'h00;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_load(input int a, input int len);
        logic [63:0] r = 64'd0;
        for (int i = 0; i < (1 << len); i++) r[i*8 +: 8] = ref_mem[a + i];
        return r;
    endfunction

    task automatic ref_store(input int a, input int len, input logic [63:0] d);
        for (int i = 0; i < 8; i++) begin
            if (i < (1 << len)) ref_mem[a + i] = d[i*8 +: 8];
`ifndef SCRATCHPAD_CTRL_RMW_EN
            else ref_mem[a + i] = 8'h00;
`endif
        end
    endtask

    function automatic int exp_latency(input logic wr, input int len, input logic err);
        if (err) return 1;
        if (!wr) return 3;
`ifdef SCRATCHPAD_CTRL_RMW_EN
        return (len == 3) ? 2 : 4;
`else
        return 2;
`endif
    endfunction

    function automatic int exp_ram_cycles(input logic wr, input int len, input logic err);
        if (err) return 0;
        if (!wr) return 1;
`ifdef SCRATCHPAD_CTRL_RMW_EN
        return (len == 3) ? 1 : 2;
`else
        return 1;
`endif
    endfunction

    // Issue one request with resp_ready high; returns data, error, latency
    // (cycles from accept edge to first resp_valid) and idle cycles before accept.
    task automatic do_req(input logic wr, input logic [1:0] len, input logic [AW-1:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rdata,
                          output logic err, output int lat, output int waits);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_wr     = wr;
        bus.req_len    = len;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.resp_ready = 1'b1;
        waits = 0;
        while (!bus.req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset          = 1'b1;
        ram_clear      = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_len    = 2'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = 64'd0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        ram_clear = 1'b0;
        total++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || ram_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: ready=%b resp_valid=%b ram_en=%b required 0 0 0",
                     bus.req_ready, bus.resp_valid, ram_en);
        end
        reset = 1'b0;
        #1;
        total++;
        if (bus.req_ready !== 1'b1 || bus.resp_rdata !== 64'd0 || bus.resp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b rdata=%h err=%b required 1 0 0",
                     bus.req_ready, bus.resp_rdata, bus.resp_err);
        end
    endtask

    task automatic test_directed();
        logic [63:0] rd;
        logic        er;
        int          lat, w;
        logic [63:0] exp_sub;
`ifdef SCRATCHPAD_CTRL_RMW_EN
        exp_sub = 64'h1122_3344_55AB_7788;
`else
        exp_sub = 64'h0000_0000_00AB_7788;
`endif
        do_req(1'b1, 2'd3, 10'h010, 64'h1122_3344_5566_7788, rd, er, lat, w);
        ref_store(16, 3, 64'h1122_3344_5566_7788);
        total++;
        if (rd !== 64'd0 || er !== 1'b0 || lat != 2) begin
            bad++;
            $display("FAIL store8: rdata=%h err=%b lat=%0d required 0 0 2", rd, er, lat);
        end
        do_req(1'b0, 2'd3, 10'h010, 64'd0, rd, er, lat, w);
        total++;
        if (rd !== 64'h1122_3344_5566_7788 || er !== 1'b0 || lat != 3) begin
            bad++;
            $display("FAIL load8: rdata=%h err=%b lat=%0d required 1122334455667788 0 3", rd, er, lat);
        end
        do_req(1'b1, 2'd0, 10'h012, 64'h0000_0000_0000_00AB, rd, er, lat, w);
        ref_store(18, 0, 64'hAB);
        total++;
        if (rd !== 64'd0 || er !== 1'b0 || lat != exp_latency(1'b1, 0, 1'b0)) begin
            bad++;
            $display("FAIL store1: rdata=%h err=%b lat=%0d required 0 0 %0d",
                     rd, er, lat, exp_latency(1'b1, 0, 1'b0));
        end
        do_req(1'b0, 2'd3, 10'h010, 64'd0, rd, er, lat, w);
        total++;
        if (rd !== exp_sub || er !== 1'b0) begin
            bad++;
            $display("FAIL merge_load: rdata=%h err=%b required %h 0", rd, er, exp_sub);
        end
        do_req(1'b0, 2'd1, 10'h010, 64'd0, rd, er, lat, w);
        total++;
        if (rd !== 64'h0000_0000_0000_7788 || er !== 1'b0 || lat != 3) begin
            bad++;
            $display("FAIL load2: rdata=%h err=%b lat=%0d required 7788 0 3", rd, er, lat);
        end
    endtask

    task automatic test_bounds();
        logic [63:0] rd;
        logic        er;
        int          lat, w, en0;
        for (int l = 0; l < 4; l++) begin
            en0 = ram_en_cnt;
            do_req(l[0], 2'(l), AW'(DEPTH - 7 + 2 * l), 64'hFFFF_FFFF_FFFF_FFFF, rd, er, lat, w);
            total++;
            if (er !== 1'b1 || rd !== 64'd0 || lat != 1 || ram_en_cnt != en0) begin
                bad++;
                $display("FAIL oob_len%0d: err=%b rdata=%h lat=%0d ram_cycles=%0d required 1 0 1 0",
                         l, er, rd, lat, ram_en_cnt - en0);
            end
        end
        do_req(1'b1, 2'd3, AW'(DEPTH - 8), 64'hCAFE_F00D_1234_5678, rd, er, lat, w);
        ref_store(DEPTH - 8, 3, 64'hCAFE_F00D_1234_5678);
        do_req(1'b0, 2'd3, AW'(DEPTH - 8), 64'd0, rd, er, lat, w);
        total++;
        if (er !== 1'b0 || rd !== 64'hCAFE_F00D_1234_5678) begin
            bad++;
            $display("FAIL top_legal: err=%b rdata=%h required 0 cafef00d12345678", er, rd);
        end
    endtask

    task automatic test_stall();
        logic [63:0] snap, rd;
        logic        er;
        int          g, en0, lat, w;
        logic        ok;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_wr     = 1'b0;
        bus.req_len    = 2'd3;
        bus.req_addr   = 10'h010;
        g = 0;
        while (!bus.req_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        g = 0;
        while (!bus.resp_valid && g < 50) begin @(negedge clk); g++; end
        snap = bus.resp_rdata;
        en0  = ram_en_cnt;
        total++;
        if (snap !== ref_load(16, 3)) begin
            bad++;
            $display("FAIL stall_data: rdata=%h required %h", snap, ref_load(16, 3));
        end
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== snap || bus.resp_err !== 1'b0 ||
                bus.req_ready !== 1'b0 || ram_en !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok || ram_en_cnt != en0) begin
            bad++;
            $display("FAIL stall_hold: stable=%b ram_cycles=%0d required 1 0", ok, ram_en_cnt - en0);
        end
        bus.resp_ready = 1'b1;
        do_req(1'b0, 2'd2, 10'h010, 64'd0, rd, er, lat, w);
        total++;
        if (w != 0 || rd !== ref_load(16, 2) || lat != 3) begin
            bad++;
            $display("FAIL stall_b2b: waits=%0d rdata=%h lat=%0d required 0 %h 3", w, rd, lat, ref_load(16, 2));
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd;
        logic        er;
        int          lat, w, g, wr0;
        logic        ok;
        do_req(1'b1, 2'd3, 10'h040, 64'h0102_0304_0506_0708, rd, er, lat, w);
        ref_store(64, 3, 64'h0102_0304_0506_0708);
        @(negedge clk);
        bus.req_valid = 1'b1;
`ifdef SCRATCHPAD_CTRL_RMW_EN
        bus.req_wr = 1'b1;
`else
        bus.req_wr = 1'b0;
`endif
        bus.req_len   = 2'd0;
        bus.req_addr  = 10'h041;
        bus.req_wdata = 64'hEE;
        g = 0;
        while (!bus.req_ready && g < 50) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        wr0   = ram_wr_cnt;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bus.resp_valid !== 1'b0 || ram_en !== 1'b0 || bus.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_state: resp_valid=%b ram_en=%b ready=%b required 0 0 0",
                     bus.resp_valid, ram_en, bus.req_ready);
        end
        reset = 1'b0;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok || ram_wr_cnt != wr0) begin
            bad++;
            $display("FAIL reset_mid_drop: quiet=%b writes=%0d required 1 0", ok, ram_wr_cnt - wr0);
        end
        do_req(1'b0, 2'd3, 10'h040, 64'd0, rd, er, lat, w);
        total++;
        if (rd !== 64'h0102_0304_0506_0708 || er !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_mem: rdata=%h err=%b required 0102030405060708 0", rd, er);
        end
    endtask

    task automatic test_random();
        logic [63:0] rd, wd, erd;
        logic        er, wr, eerr;
        logic [1:0]  len;
        int          a, lat, w, en0, mism;
        mism = 0;
        for (int n = 0; n < 80; n++) begin
            wr  = 1'($urandom % 2);
            len = 2'($urandom % 4);
            a   = ($urandom % 6 == 0) ? (DEPTH - 12 + int'($urandom % 12)) : int'($urandom_range(0, 63));
            wd  = {$urandom, $urandom};
            eerr = (a > DEPTH - 8);
            erd  = (eerr || wr) ? 64'd0 : ref_load(a, int'(len));
            en0  = ram_en_cnt;
            do_req(wr, len, AW'(a), wd, rd, er, lat, w);
            if (wr && !eerr) ref_store(a, int'(len), wd);
            total++;
            if (rd !== erd || er !== eerr || lat != exp_latency(wr, int'(len), eerr) || w != 0 ||
                ram_en_cnt - en0 != exp_ram_cycles(wr, int'(len), eerr)) begin
                bad++;
                mism++;
                if (mism < 10)
                    $display("FAIL random_%0d: wr=%b len=%0d addr=%0d got rdata=%h err=%b lat=%0d waits=%0d cyc=%0d required %h %b %0d 0 %0d",
                             n, wr, len, a, rd, er, lat, w, ram_en_cnt - en0, erd, eerr,
                             exp_latency(wr, int'(len), eerr), exp_ram_cycles(wr, int'(len), eerr));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_bounds();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
